stackcalc_core: RTL and testbench
=================================

Name: stackcalc_core

Overview:
- 8-bit RPN stack calculator for a TinyTapeout-style 8-in/8-out slot.
- Accepts 4-bit nibbles and 4-bit opcodes on a packed input bus.
- Keeps an 8-deep stack of 8-bit words.
- Continuously drives the top of stack (TOS) on the output bus.
- Top-level user block; no other interfaces.

Parameters:
- DEPTH, 8: number of stack entries. Must be ≥ 3 so that ROT/OVER are defined.

Ports:
- io_in[0]  input  1  clk, the single clock; all state updates on its rising edge.
- io_in[1]  input  1  rst; reset is synchronous and active-high.
- io_in[5:2]  input  4  nib: data nibble or opcode.
- io_in[7:6]  input  2  mode: command class.
- io_out  output  8  TOS, driven directly from the S0 register.

Behaviour:
- State: S0..S(DEPTH-1), each 8 bits; S0 is TOS. The stack is shift-register style, with no pointer and no full/empty flags.
- Reset: when rst=1 at a rising clk, all entries clear to 0 and io_out=0 after that edge. Reset has priority over every mode.
- Reset mid-sequence discards all contents.
- Latency: a command sampled at rising edge N is visible on io_out immediately after edge N. There is no handshake; one command is executed per clock.
- Push semantics: S(i+1)<=S(i), and S(DEPTH-1) is lost silently on overflow.
- Pop semantics: S(i)<=S(i+1), and S(DEPTH-1)<=0. Underflow therefore reads zeros.
- mode=00 (HOLD): no change.
- mode=01 (PUSH): push {4'b0, nib}.
- mode=10 (SHIFT-IN): S0<={S0[3:0], nib}, with no push. Builds byte literals (push the high nibble, then shift in the low nibble).
- mode=11 (OP): nib selects the operation. A = S1, B = S0. Binary ops pop once and write the result to the new S0. All arithmetic is modulo 256, unsigned.
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: S0<=~S0 (unary, no pop)
  - 6 NEG: S0<=-S0 (unary)
  - 7 SHL: S0<=S0<<1, zero fill
  - 8 SHR: S0<=S0>>1, logical
  - 9 DUP: push S0
  - A DROP: pop
  - B SWAP: S0<=S1, S1<=S0
  - C OVER: push S1
  - D MUL: low 8 bits of A*B (binary)
  - E ROT: S0<=S2, S1<=S0, S2<=S1
  - F CLEAR: all entries <=0; same effect as reset but without using rst
- Entries not named by an operation keep their value, except that push/pop shift them as described.
- No X propagation: all registers are reset, and undefined combinations do not exist (all 16 opcodes are defined).

Test Plan:
- Reset: rst=1 for one edge → io_out=0x00. Then mode=00 for 3 edges → io_out stays 0x00.
- Arithmetic: PUSH 3, PUSH 5, OP 0 (ADD) → 0x08. Then PUSH 2, OP D (MUL) → 0x10. Then PUSH 1, OP 1 (SUB) → 0x0F.
- Literal and wrap: PUSH 0xA, SHIFT-IN 0x5 → 0xA5. PUSH 0x5B... (i.e. PUSH 5, SHIFT-IN B) → 0x5B. Then ADD → 0x00 (0xA5+0x5B wraps).
- Underflow: reset, PUSH 2, PUSH 5, SUB → 0xFD. DROP → 0x00. Further DROP → still 0x00.
- Overflow: reset, PUSH 1..9 (nine pushes) → 0x09. Then eight DROPs show 0x08..0x02, then 0x00; the value 1 was lost.
- Stack ops and reset priority: PUSH 1, PUSH 2, PUSH 3, ROT → 0x01. SWAP → 0x03. OVER → 0x01. Then assert rst together with mode=01, nib=7 → 0x00. CLEAR after pushes → 0x00.

Source files
------------

// File: rtl/stackcalc_core.sv
// stackcalc_core: 8-bit RPN stack calculator for an 8-in/8-out tile slot.
//
// One command is executed on every rising clock edge. The stack is a chain
// of DEPTH byte registers with no pointer. S0 is the top of stack and drives
// io_out directly, so a command's result is visible right after its edge.
//
// Ports:
//   io_in[0]    clk   single clock, rising-edge active
//   io_in[1]    rst   synchronous, active-high; clears every entry
//   io_in[5:2]  nib   data nibble (PUSH / SHIFT-IN) or opcode (OP)
//   io_in[7:6]  mode  00 HOLD, 01 PUSH, 10 SHIFT-IN, 11 OP
//   io_out      S0    top of stack
module stackcalc_core #(
  parameter int DEPTH = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int DATA_W = 8;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_PUSH  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_OP    = 2'b11;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_NEG   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_DUP   = 4'h9;
  localparam logic [3:0] OP_DROP  = 4'hA;
  localparam logic [3:0] OP_SWAP  = 4'hB;
  localparam logic [3:0] OP_OVER  = 4'hC;
  localparam logic [3:0] OP_MUL   = 4'hD;
  localparam logic [3:0] OP_ROT   = 4'hE;
  localparam logic [3:0] OP_CLEAR = 4'hF;

  logic       clk;
  logic       rst;
  logic [3:0] nib;
  logic [1:0] mode;

  assign clk  = io_in[0];
  assign rst  = io_in[1];
  assign nib  = io_in[5:2];
  assign mode = io_in[7:6];

  logic [DATA_W-1:0] stk     [DEPTH];
  logic [DATA_W-1:0] stk_nxt [DEPTH];

  // Two-operand operations: a is S1, b is S0. Unsigned, modulo 256.
  function automatic logic [DATA_W-1:0] alu_bin(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    case (op)
      OP_ADD:  alu_bin = a + b;
      OP_SUB:  alu_bin = a - b;
      OP_AND:  alu_bin = a & b;
      OP_OR:   alu_bin = a | b;
      OP_XOR:  alu_bin = a ^ b;
      OP_MUL:  alu_bin = a * b;
      default: alu_bin = '0;
    endcase
  endfunction

  // Single-operand operations on S0.
  function automatic logic [DATA_W-1:0] alu_un(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] b
  );
    case (op)
      OP_NOT:  alu_un = ~b;
      OP_NEG:  alu_un = (~b) + 8'd1;
      OP_SHL:  alu_un = {b[DATA_W-2:0], 1'b0};
      OP_SHR:  alu_un = {1'b0, b[DATA_W-1:1]};
      default: alu_un = b;
    endcase
  endfunction

  // Next-state selection. Everything defaults to "keep"; push shifts every
  // entry down by one, pop shifts up by one and zero-fills the bottom so that
  // underflow reads zeros.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stk_nxt[i] = stk[i];
    end
    case (mode)
      MODE_HOLD: begin
      end
      MODE_PUSH: begin
        for (int i = 1; i < DEPTH; i++) begin
          stk_nxt[i] = stk[i-1];
        end
        stk_nxt[0] = {4'b0000, nib};
      end
      MODE_SHIFT: begin
        stk_nxt[0] = {stk[0][3:0], nib};
      end
      MODE_OP: begin
        case (nib)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL: begin
            // Binary op: pop once, result lands in the new S0.
            for (int i = 0; i < DEPTH - 1; i++) begin
              stk_nxt[i] = stk[i+1];
            end
            stk_nxt[DEPTH-1] = '0;
            stk_nxt[0] = alu_bin(nib, stk[1], stk[0]);
          end
          OP_NOT, OP_NEG, OP_SHL, OP_SHR: begin
            stk_nxt[0] = alu_un(nib, stk[0]);
          end
          OP_DUP, OP_OVER: begin
            for (int i = 1; i < DEPTH; i++) begin
              stk_nxt[i] = stk[i-1];
            end
            stk_nxt[0] = (nib == OP_DUP) ? stk[0] : stk[1];
          end
          OP_DROP: begin
            for (int i = 0; i < DEPTH - 1; i++) begin
              stk_nxt[i] = stk[i+1];
            end
            stk_nxt[DEPTH-1] = '0;
          end
          OP_SWAP: begin
            stk_nxt[0] = stk[1];
            stk_nxt[1] = stk[0];
          end
          OP_ROT: begin
            stk_nxt[0] = stk[2];
            stk_nxt[1] = stk[0];
            stk_nxt[2] = stk[1];
          end
          OP_CLEAR: begin
            for (int i = 0; i < DEPTH; i++) begin
              stk_nxt[i] = '0;
            end
          end
          default: begin
          end
        endcase
      end
      default: begin
      end
    endcase
  end

  // Stack register update; reset overrides any command on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stk[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stk[i] <= stk_nxt[i];
      end
    end
  end

  assign io_out = stk[0];

endmodule

// File: tb/tb_stackcalc_core.sv
// tb_stackcalc_core: self-checking bench for stackcalc_core.
//
// Directed scenarios compare io_out against hand-derived constants; a random
// scenario compares against a queue-based stack model. Inputs change on the
// falling edge, io_out is sampled 1 time unit after the rising edge.
module tb_stackcalc_core;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] nib = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mdl[$];

  assign io_in = {mode, nib, rst, clk};

  stackcalc_core #(.DEPTH(DEPTH)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    mdl.delete();
    repeat (DEPTH) mdl.push_back(8'h00);
  endtask

  task automatic model_push(input logic [7:0] v);
    mdl.push_front(v);
    void'(mdl.pop_back());
  endtask

  task automatic model_pop();
    void'(mdl.pop_front());
    mdl.push_back(8'h00);
  endtask

  task automatic model_binary(input int v);
    model_pop();
    mdl[0] = 8'(v % 256);
  endtask

  task automatic model_step(input logic r, input logic [1:0] m, input logic [3:0] n);
    int a, b, c;
    if (r || (m == 2'b11 && n == 4'hF)) begin
      model_reset();
      return;
    end
    b = int'(mdl[0]);
    a = int'(mdl[1]);
    c = int'(mdl[2]);
    case (m)
      2'b00: ;
      2'b01: model_push({4'h0, n});
      2'b10: mdl[0] = 8'((b % 16) * 16 + int'(n));
      default: begin
        case (n)
          4'h0: model_binary(a + b);
          4'h1: model_binary(a - b + 256);
          4'h2: model_binary(a & b);
          4'h3: model_binary(a | b);
          4'h4: model_binary(a ^ b);
          4'h5: mdl[0] = 8'(255 - b);
          4'h6: mdl[0] = 8'((256 - b) % 256);
          4'h7: mdl[0] = 8'((b * 2) % 256);
          4'h8: mdl[0] = 8'(b / 2);
          4'h9: model_push(8'(b));
          4'hA: model_pop();
          4'hB: begin mdl[0] = 8'(a); mdl[1] = 8'(b); end
          4'hC: model_push(8'(a));
          4'hD: model_binary(a * b);
          4'hE: begin mdl[0] = 8'(c); mdl[1] = 8'(b); mdl[2] = 8'(a); end
          default: ;
        endcase
      end
    endcase
  endtask

  // Drive one command for exactly one rising edge and advance the model.
  task automatic apply(input logic r, input logic [1:0] m, input logic [3:0] n);
    @(negedge clk);
    rst = r; mode = m; nib = n;
    @(posedge clk);
    #1;
    model_step(r, m, n);
    rst = 1'b0; mode = 2'b00; nib = 4'h0;
  endtask

  function automatic logic [14:0] enc(input logic r, input logic [1:0] m,
                                      input logic [3:0] n, input logic [7:0] e);
    return {r, m, n, e};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [14:0] seq[$];
    seq.push_back(enc(1, 2'b00, 4'h0, 8'h00));
    repeat (3) seq.push_back(enc(0, 2'b00, 4'h0, 8'h00));
    foreach (seq[k]) begin
      apply(seq[k][14], seq[k][13:12], seq[k][11:8]);
      vectors++;
      if (io_out !== seq[k][7:0]) begin
        miscompares++;
        $display("FAIL reset step %0d: io_out=%02h expected %02h", k, io_out, seq[k][7:0]);
      end
    end
  endtask

  task automatic test_arith();
    logic [14:0] seq[$];
    seq = '{enc(1, 2'b00, 4'h0, 8'h00),
            enc(0, 2'b01, 4'h3, 8'h03), enc(0, 2'b01, 4'h5, 8'h05),
            enc(0, 2'b11, 4'h0, 8'h08), enc(0, 2'b01, 4'h2, 8'h02),
            enc(0, 2'b11, 4'hD, 8'h10), enc(0, 2'b01, 4'h1, 8'h01),
            enc(0, 2'b11, 4'h1, 8'h0F)};
    foreach (seq[k]) begin
      apply(seq[k][14], seq[k][13:12], seq[k][11:8]);
      vectors++;
      if (io_out !== seq[k][7:0]) begin
        miscompares++;
        $display("FAIL arith step %0d: io_out=%02h expected %02h", k, io_out, seq[k][7:0]);
      end
    end
  endtask

  task automatic test_literal_wrap();
    logic [14:0] seq[$];
    seq = '{enc(1, 2'b00, 4'h0, 8'h00),
            enc(0, 2'b01, 4'hA, 8'h0A), enc(0, 2'b10, 4'h5, 8'hA5),
            enc(0, 2'b01, 4'h5, 8'h05), enc(0, 2'b10, 4'hB, 8'h5B),
            enc(0, 2'b11, 4'h0, 8'h00)};
    foreach (seq[k]) begin
      apply(seq[k][14], seq[k][13:12], seq[k][11:8]);
      vectors++;
      if (io_out !== seq[k][7:0]) begin
        miscompares++;
        $display("FAIL literal step %0d: io_out=%02h expected %02h", k, io_out, seq[k][7:0]);
      end
    end
  endtask

  task automatic test_logic_unary();
    logic [14:0] seq[$];
    seq = '{enc(1, 2'b00, 4'h0, 8'h00),
            enc(0, 2'b01, 4'hF, 8'h0F), enc(0, 2'b10, 4'h0, 8'hF0),
            enc(0, 2'b01, 4'h3, 8'h03), enc(0, 2'b10, 4'hC, 8'h3C),
            enc(0, 2'b11, 4'h2, 8'h30), enc(0, 2'b01, 4'hF, 8'h0F),
            enc(0, 2'b11, 4'h3, 8'h3F), enc(0, 2'b01, 4'h5, 8'h05),
            enc(0, 2'b10, 4'h5, 8'h55), enc(0, 2'b11, 4'h4, 8'h6A),
            enc(0, 2'b11, 4'h9, 8'h6A), enc(0, 2'b11, 4'h0, 8'hD4),
            enc(0, 2'b01, 4'h8, 8'h08), enc(0, 2'b10, 4'h1, 8'h81),
            enc(0, 2'b11, 4'h5, 8'h7E), enc(0, 2'b11, 4'h6, 8'h82),
            enc(0, 2'b11, 4'h7, 8'h04), enc(0, 2'b11, 4'h8, 8'h02),
            enc(0, 2'b11, 4'hA, 8'hD4)};
    foreach (seq[k]) begin
      apply(seq[k][14], seq[k][13:12], seq[k][11:8]);
      vectors++;
      if (io_out !== seq[k][7:0]) begin
        miscompares++;
        $display("FAIL logic_unary step %0d: io_out=%02h expected %02h", k, io_out, seq[k][7:0]);
      end
    end
  endtask

  task automatic test_underflow();
    logic [14:0] seq[$];
    seq = '{enc(1, 2'b00, 4'h0, 8'h00),
            enc(0, 2'b01, 4'h2, 8'h02), enc(0, 2'b01, 4'h5, 8'h05),
            enc(0, 2'b11, 4'h1, 8'hFD), enc(0, 2'b11, 4'hA, 8'h00),
            enc(0, 2'b11, 4'hA, 8'h00), enc(0, 2'b11, 4'h0, 8'h00)};
    foreach (seq[k]) begin
      apply(seq[k][14], seq[k][13:12], seq[k][11:8]);
      vectors++;
      if (io_out !== seq[k][7:0]) begin
        miscompares++;
        $display("FAIL underflow step %0d: io_out=%02h expected %02h", k, io_out, seq[k][7:0]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [14:0] seq[$];
    seq.push_back(enc(1, 2'b00, 4'h0, 8'h00));
    for (int i = 1; i <= 9; i++) seq.push_back(enc(0, 2'b01, 4'(i), 8'(i)));
    for (int i = 8; i >= 2; i--) seq.push_back(enc(0, 2'b11, 4'hA, 8'(i)));
    seq.push_back(enc(0, 2'b11, 4'hA, 8'h00));
    seq.push_back(enc(0, 2'b11, 4'hA, 8'h00));
    foreach (seq[k]) begin
      apply(seq[k][14], seq[k][13:12], seq[k][11:8]);
      vectors++;
      if (io_out !== seq[k][7:0]) begin
        miscompares++;
        $display("FAIL overflow step %0d: io_out=%02h expected %02h", k, io_out, seq[k][7:0]);
      end
    end
  endtask

  task automatic test_stack_ops();
    logic [14:0] seq[$];
    seq = '{enc(1, 2'b00, 4'h0, 8'h00),
            enc(0, 2'b01, 4'h1, 8'h01), enc(0, 2'b01, 4'h2, 8'h02),
            enc(0, 2'b01, 4'h3, 8'h03), enc(0, 2'b11, 4'hE, 8'h01),
            enc(0, 2'b11, 4'hB, 8'h03), enc(0, 2'b11, 4'hC, 8'h01),
            enc(0, 2'b11, 4'hA, 8'h03), enc(0, 2'b11, 4'hA, 8'h01),
            enc(0, 2'b11, 4'hA, 8'h02), enc(0, 2'b01, 4'h9, 8'h09),
            enc(1, 2'b01, 4'h7, 8'h00), enc(0, 2'b11, 4'hA, 8'h00),
            enc(0, 2'b01, 4'h4, 8'h04), enc(0, 2'b01, 4'h6, 8'h06),
            enc(0, 2'b11, 4'hF, 8'h00), enc(0, 2'b11, 4'hA, 8'h00)};
    foreach (seq[k]) begin
      apply(seq[k][14], seq[k][13:12], seq[k][11:8]);
      vectors++;
      if (io_out !== seq[k][7:0]) begin
        miscompares++;
        $display("FAIL stack_ops step %0d: io_out=%02h expected %02h", k, io_out, seq[k][7:0]);
      end
    end
  endtask

  task automatic test_random();
    logic       r;
    logic [1:0] m;
    logic [3:0] n;
    apply(1'b1, 2'b00, 4'h0);
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 59) == 0);
      m = 2'($urandom_range(0, 3));
      n = 4'($urandom_range(0, 15));
      // Keep CLEAR rare so the stack fills up and exercises overflow.
      if (m == 2'b11 && n == 4'hF && $urandom_range(0, 3) != 0) n = 4'h0;
      apply(r, m, n);
      vectors++;
      if (io_out !== mdl[0]) begin
        miscompares++;
        $display("FAIL random step %0d (rst=%0b mode=%0d nib=%0h): io_out=%02h expected %02h",
                 k, r, m, n, io_out, mdl[0]);
      end
    end
    // Drain the whole stack so every hidden entry is observed on io_out.
    for (int k = 0; k < DEPTH + 1; k++) begin
      apply(1'b0, 2'b11, 4'hA);
      vectors++;
      if (io_out !== mdl[0]) begin
        miscompares++;
        $display("FAIL random_drain step %0d: io_out=%02h expected %02h", k, io_out, mdl[0]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arith();
    test_literal_wrap();
    test_logic_unary();
    test_underflow();
    test_overflow();
    test_stack_ops();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
